tlb_op_unit: RTL and testbench
==============================

Name: tlb_op_unit

Overview:
- Initiator side of the TLB maintenance interface: executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB for the pipeline.
- Drives the TLB write port, read port, invtlb port and search port 1.
- Returns CSR writeback data to the CSR file.
- Sits between the EX/MEM-stage TLB-instruction decode and the TLB array, and owns the fill-index policy.

Parameters:
- TLBNUM, 16: number of TLB entries; must be a power of two ≥ 2. IW = $clog2(TLBNUM).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request valid
- op_ready  out  1  unit idle, can accept a request
- op_type  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 NOP
- op_invtlb_op  in  5  INVTLB op field
- op_asid  in  10  INVTLB rj[9:0]
- op_va  in  32  INVTLB rk
- op_done  out  1  one-cycle completion pulse
- csr_asid  in  10  ASID.ASID
- csr_tlbehi  in  32  TLBEHI; VPPN=[31:13]
- csr_tlbidx  in  32  TLBIDX; INDEX=[IW-1:0], PS=[29:24], NE=[31]
- csr_tlbelo0, csr_tlbelo1  in  32 each  V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8]
- csr_estat_ecode  in  6  ESTAT.Ecode
- s1_vppn/s1_va_bit12/s1_asid  out  19/1/10  search port 1 key
- s1_found/s1_index  in  1/IW  search port 1 result
- s1_owned  out  1  core must route port 1 from this unit
- invtlb_valid/invtlb_op  out  1/5  to TLB
- we/w_index/w_e/w_vppn/w_ps/w_asid/w_g  out  1/IW/1/19/6/10/1  write port
- w_ppn0/w_plv0/w_mat0/w_d0/w_v0, w_ppn1/w_plv1/w_mat1/w_d1/w_v1  out  20/2/2/1/1 each set
- r_index  out  IW  read index
- r_e/r_vppn/r_ps/r_asid/r_g and r_{ppn,plv,mat,d,v}{0,1}  in  widths as write port
- srch_wb_valid/srch_wb_ne/srch_wb_index  out  1/1/IW
- rd_wb_valid/rd_wb_ne/rd_wb_ps/rd_wb_asid  out  1/1/6/10
- rd_wb_tlbehi/rd_wb_tlbelo0/rd_wb_tlbelo1  out  32 each

Behaviour:
- FSM states: IDLE → EXEC → DONE → IDLE.
  - op_ready = (state==IDLE) & ~reset.
  - On accept (op_valid & op_ready, cycle T), op_type, op_invtlb_op, op_asid and op_va are registered.
- EXEC (T+1): drive the TLB combinationally from the registered op and the live CSR inputs. CSRs are stable while busy.
  - SRCH: s1_owned=1; s1_vppn=tlbehi[31:13]; s1_va_bit12=0; s1_asid=csr_asid. Register s1_found and s1_index.
  - RD: r_index=tlbidx[IW-1:0]. Register all r_* fields.
  - WR/FILL: we=1 for one cycle.
    - w_index = tlbidx INDEX (WR) or the fill index (FILL).
    - w_e = (ecode==6'h3F) | ~tlbidx[31].
    - w_vppn=tlbehi[31:13]; w_ps=tlbidx[29:24]; w_asid=csr_asid; w_g=elo0.G & elo1.G.
    - ppn/plv/mat/d/v taken from elo0/elo1.
  - INV: s1_owned=1; s1_vppn=op_va[31:13]; s1_va_bit12=op_va[12]; s1_asid=op_asid; invtlb_op=registered op.
    - invtlb_valid=1 only if the op ≤ 6; otherwise no invalidation.
  - NOP: no TLB activity.
- DONE (T+2): op_done=1.
  - SRCH: srch_wb_valid=1; srch_wb_ne=~found; srch_wb_index=index (0 on miss).
  - RD: rd_wb_valid=1.
    - If r_e=1: ehi={vppn,13'b0}; elo={4'b0,ppn,1'b0,g,mat,plv,d,v}; ps=r_ps; asid=r_asid; ne=0.
    - If r_e=0: ne=1 and all other rd_wb fields are 0.
- op_ready returns at T+3. Back-to-back throughput: one op per 3 cycles.
- Idle values: we, invtlb_valid, s1_owned, all *_valid and op_done are 0 outside their cycle; data outputs are 0 when not valid.
- Fill index: round-robin counter advanced once per FILL EXEC; wraps TLBNUM-1 → 0.
- Reset (any state, including EXEC/DONE):
  - Next state IDLE; fill index 0; all outputs 0.
  - No op_done or writeback for the aborted op.
  - A we/invtlb_valid already asserted in the reset cycle is suppressed (gated by ~reset).

Optional Feature:
- TLB_FILL_LFSR_EN defined: fill index = low IW bits of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'h01 on reset, advanced every clock.
- TLB_FILL_LFSR_EN undefined: round-robin counter as described in Behaviour.

Decomposition:
- Package tlb_pkg: op_type encodings; CSR field bit positions; ECODE_TLBR=6'h3F; PS_4K=6'd12, PS_4M=6'd21; INVTLB_OP_MAX=5'd6.
- Sub-module tlb_fill_idx_gen holds the counter/LFSR, with inputs clk, reset, adv and output idx[IW-1:0].

Test Plan:
- WR: tlbidx INDEX=5, PS=12, NE=0; ehi=0x12346000; asid=0x21; both G=1 → at T+1 we=1, w_index=5, w_vppn=0x091A3, w_e=1, w_g=1; op_done at T+2.
- SRCH hit, TLB returns found=1, index=7 → srch_wb_ne=0, index=7. Miss → ne=1, index=0.
- RD on an entry with r_e=0 → rd_wb_ne=1; tlbehi/elo0/elo1/ps/asid all 0. Valid 4MB entry → rd_wb_ps=21 and the ELO layout is repacked exactly.
- 17 FILLs after reset (TLBNUM=16) → w_index 0..15 then 0. With ecode=0x3F and NE=1 → w_e=1.
- INV op=5, asid=0x21, va=0x12345000 → one-cycle invtlb_valid, s1_vppn=0x091A2, s1_asid=0x21, s1_owned=1. Op=9 → invtlb_valid stays 0 and op_done still pulses.
- Reset asserted during EXEC of a WR → we=0 that cycle, no op_done, op_ready=1 the cycle after reset deasserts, fill index 0.

Source files
------------

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared encodings, CSR field positions and state type for the TLB op unit
package tlb_pkg;
    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;
    localparam logic [4:0] INVTLB_OP_MAX = 5'd6;
    localparam int IDX_NE   = 31;
    localparam int IDX_PS   = 24;
    localparam int EHI_VPPN = 13;
    localparam int ELO_V    = 0;
    localparam int ELO_D    = 1;
    localparam int ELO_PLV  = 2;
    localparam int ELO_MAT  = 4;
    localparam int ELO_G    = 6;
    localparam int ELO_PPN  = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
    function automatic logic [31:0] pack_elo(input logic [19:0] ppn, input logic g,
                                             input logic [1:0] mat, input logic [1:0] plv,
                                             input logic d, input logic v);
        return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
    endfunction
endpackage

// File: rtl/tlb_fill_idx_gen.sv
// tlb_fill_idx_gen: TLBFILL victim index; round-robin by default, LFSR when TLB_FILL_LFSR_EN is defined
module tlb_fill_idx_gen #(
    parameter int TLBNUM = 16,
    parameter int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    output logic [IW-1:0] idx
);
`ifdef TLB_FILL_LFSR_EN
    logic [7:0] r_lfsr;
    logic       w_unused;
    assign w_unused = ^{adv, r_lfsr};
    assign idx = r_lfsr[IW-1:0];
    // free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR
    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= 8'h01;
        else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
`else
    logic [IW-1:0] r_idx;
    assign idx = r_idx;
    // advance once per fill; power-of-two size makes the wrap free
    always_ff @(posedge clk) begin
        if (reset)    r_idx <= '0;
        else if (adv) r_idx <= r_idx + 1'b1;
    end
`endif
endmodule

// File: rtl/tlb_op_unit.sv
// tlb_op_unit: initiator for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB; optional TLB_FILL_LFSR_EN selects LFSR fill index
module tlb_op_unit
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_type,
    input  logic [4:0]    op_invtlb_op,
    input  logic [9:0]    op_asid,
    input  logic [31:0]   op_va,
    output logic          op_done,
    input  logic [9:0]    csr_asid,
    input  logic [31:0]   csr_tlbehi,
    input  logic [31:0]   csr_tlbidx,
    input  logic [31:0]   csr_tlbelo0,
    input  logic [31:0]   csr_tlbelo1,
    input  logic [5:0]    csr_estat_ecode,
    output logic [18:0]   s1_vppn,
    output logic          s1_va_bit12,
    output logic [9:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          s1_owned,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic [18:0]   w_vppn,
    output logic [5:0]    w_ps,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_ppn0,
    output logic [1:0]    w_plv0,
    output logic [1:0]    w_mat0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_ppn1,
    output logic [1:0]    w_plv1,
    output logic [1:0]    w_mat1,
    output logic          w_d1,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_ppn0,
    input  logic [1:0]    r_plv0,
    input  logic [1:0]    r_mat0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_ppn1,
    input  logic [1:0]    r_plv1,
    input  logic [1:0]    r_mat1,
    input  logic          r_d1,
    input  logic          r_v1,
    output logic          srch_wb_valid,
    output logic          srch_wb_ne,
    output logic [IW-1:0] srch_wb_index,
    output logic          rd_wb_valid,
    output logic          rd_wb_ne,
    output logic [5:0]    rd_wb_ps,
    output logic [9:0]    rd_wb_asid,
    output logic [31:0]   rd_wb_tlbehi,
    output logic [31:0]   rd_wb_tlbelo0,
    output logic [31:0]   rd_wb_tlbelo1
);
    state_t        r_state, w_next;
    logic [2:0]    r_op;
    logic [4:0]    r_inv_op;
    logic [9:0]    r_op_asid;
    logic [19:0]   r_va;
    logic          r_found;
    logic [IW-1:0] r_sidx;
    logic          r_rd_e;
    logic [31:0]   r_rd_ehi, r_rd_elo0, r_rd_elo1;
    logic [5:0]    r_rd_ps;
    logic [9:0]    r_rd_asid;
    logic          w_exec, w_done, w_srch, w_rd, w_wr, w_fill, w_inv, w_rd_hit;
    logic [IW-1:0] w_fill_idx;
    logic          w_unused;

    assign w_unused = ^{csr_tlbidx[30:IW], csr_tlbehi[12:0], csr_tlbelo0[31:28], csr_tlbelo0[7],
                        csr_tlbelo1[31:28], csr_tlbelo1[7], op_va[11:0]};

    assign op_ready = (r_state == ST_IDLE) & ~reset;

    // next state: a request is only taken in IDLE, then EXEC and DONE follow unconditionally
    always_comb begin
        w_next = (r_state == ST_IDLE) ? (op_valid ? ST_EXEC : ST_IDLE) :
                 (r_state == ST_EXEC) ? ST_DONE : ST_IDLE;
    end

    // state register and request capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_inv_op  <= '0;
            r_op_asid <= '0;
            r_va      <= '0;
        end else begin
            r_state <= w_next;
            if (op_valid & op_ready) begin
                r_op      <= op_type;
                r_inv_op  <= op_invtlb_op;
                r_op_asid <= op_asid;
                r_va      <= op_va[31:12];
            end
        end
    end

    assign w_exec = (r_state == ST_EXEC) & ~reset;
    assign w_done = (r_state == ST_DONE) & ~reset;
    assign w_srch = w_exec & (r_op == OP_SRCH);
    assign w_rd   = w_exec & (r_op == OP_RD);
    assign w_wr   = w_exec & (r_op == OP_WR);
    assign w_fill = w_exec & (r_op == OP_FILL);
    assign w_inv  = w_exec & (r_op == OP_INV);

    tlb_fill_idx_gen #(.TLBNUM(TLBNUM), .IW(IW)) u_fill (
        .clk(clk), .reset(reset), .adv(w_fill), .idx(w_fill_idx)
    );

    assign s1_owned     = w_srch | w_inv;
    assign s1_vppn      = w_srch ? csr_tlbehi[31:EHI_VPPN] : w_inv ? r_va[19:1] : '0;
    assign s1_va_bit12  = w_inv & r_va[0];
    assign s1_asid      = w_srch ? csr_asid : w_inv ? r_op_asid : '0;
    assign invtlb_valid = w_inv & (r_inv_op <= INVTLB_OP_MAX);
    assign invtlb_op    = invtlb_valid ? r_inv_op : '0;
    assign r_index      = w_rd ? csr_tlbidx[IW-1:0] : '0;

    assign we      = w_wr | w_fill;
    assign w_index = w_wr ? csr_tlbidx[IW-1:0] : w_fill ? w_fill_idx : '0;
    assign w_e     = we & ((csr_estat_ecode == ECODE_TLBR) | ~csr_tlbidx[IDX_NE]);
    assign w_vppn  = we ? csr_tlbehi[31:EHI_VPPN] : '0;
    assign w_ps    = we ? csr_tlbidx[IDX_PS +: 6] : '0;
    assign w_asid  = we ? csr_asid : '0;
    assign w_g     = we & csr_tlbelo0[ELO_G] & csr_tlbelo1[ELO_G];
    assign w_ppn0  = we ? csr_tlbelo0[ELO_PPN +: 20] : '0;
    assign w_plv0  = we ? csr_tlbelo0[ELO_PLV +: 2] : '0;
    assign w_mat0  = we ? csr_tlbelo0[ELO_MAT +: 2] : '0;
    assign w_d0    = we & csr_tlbelo0[ELO_D];
    assign w_v0    = we & csr_tlbelo0[ELO_V];
    assign w_ppn1  = we ? csr_tlbelo1[ELO_PPN +: 20] : '0;
    assign w_plv1  = we ? csr_tlbelo1[ELO_PLV +: 2] : '0;
    assign w_mat1  = we ? csr_tlbelo1[ELO_MAT +: 2] : '0;
    assign w_d1    = we & csr_tlbelo1[ELO_D];
    assign w_v1    = we & csr_tlbelo1[ELO_V];

    // capture the TLB's search and read responses at the end of EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            r_found   <= 1'b0;
            r_sidx    <= '0;
            r_rd_e    <= 1'b0;
            r_rd_ehi  <= '0;
            r_rd_elo0 <= '0;
            r_rd_elo1 <= '0;
            r_rd_ps   <= '0;
            r_rd_asid <= '0;
        end else begin
            if (w_srch) begin
                r_found <= s1_found;
                r_sidx  <= s1_index;
            end
            if (w_rd) begin
                r_rd_e    <= r_e;
                r_rd_ehi  <= {r_vppn, 13'b0};
                r_rd_elo0 <= pack_elo(r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0);
                r_rd_elo1 <= pack_elo(r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1);
                r_rd_ps   <= r_ps;
                r_rd_asid <= r_asid;
            end
        end
    end

    assign op_done       = w_done;
    assign srch_wb_valid = w_done & (r_op == OP_SRCH);
    assign srch_wb_ne    = srch_wb_valid & ~r_found;
    assign srch_wb_index = (srch_wb_valid & r_found) ? r_sidx : '0;
    assign rd_wb_valid   = w_done & (r_op == OP_RD);
    assign w_rd_hit      = rd_wb_valid & r_rd_e;
    assign rd_wb_ne      = rd_wb_valid & ~r_rd_e;
    assign rd_wb_tlbehi  = w_rd_hit ? r_rd_ehi : '0;
    assign rd_wb_tlbelo0 = w_rd_hit ? r_rd_elo0 : '0;
    assign rd_wb_tlbelo1 = w_rd_hit ? r_rd_elo1 : '0;
    assign rd_wb_ps      = w_rd_hit ? r_rd_ps : '0;
    assign rd_wb_asid    = w_rd_hit ? r_rd_asid : '0;
endmodule

// File: tb/tb_tlb_op_unit.sv
// tb_tlb_op_unit: directed and randomized checks of tlb_op_unit against a behavioural model
module tb_tlb_op_unit;
    localparam int IW = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          op_valid = 1'b0, op_ready, op_done;
    logic [2:0]    op_type = '0;
    logic [4:0]    op_invtlb_op = '0;
    logic [9:0]    op_asid = '0;
    logic [31:0]   op_va = '0;
    logic [9:0]    csr_asid = '0;
    logic [31:0]   csr_tlbehi = '0, csr_tlbidx = '0, csr_tlbelo0 = '0, csr_tlbelo1 = '0;
    logic [5:0]    csr_estat_ecode = '0;
    logic [18:0]   s1_vppn;
    logic          s1_va_bit12, s1_owned;
    logic [9:0]    s1_asid;
    logic          s1_found = 1'b0;
    logic [IW-1:0] s1_index = '0;
    logic          invtlb_valid;
    logic [4:0]    invtlb_op;
    logic          we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [IW-1:0] w_index, r_index;
    logic [18:0]   w_vppn;
    logic [5:0]    w_ps;
    logic [9:0]    w_asid;
    logic [19:0]   w_ppn0, w_ppn1;
    logic [1:0]    w_plv0, w_mat0, w_plv1, w_mat1;
    logic          r_e = 1'b0, r_g = 1'b0, r_d0 = 1'b0, r_v0 = 1'b0, r_d1 = 1'b0, r_v1 = 1'b0;
    logic [18:0]   r_vppn = '0;
    logic [5:0]    r_ps = '0;
    logic [9:0]    r_asid = '0;
    logic [19:0]   r_ppn0 = '0, r_ppn1 = '0;
    logic [1:0]    r_plv0 = '0, r_mat0 = '0, r_plv1 = '0, r_mat1 = '0;
    logic          srch_wb_valid, srch_wb_ne, rd_wb_valid, rd_wb_ne;
    logic [IW-1:0] srch_wb_index;
    logic [5:0]    rd_wb_ps;
    logic [9:0]    rd_wb_asid;
    logic [31:0]   rd_wb_tlbehi, rd_wb_tlbelo0, rd_wb_tlbelo1;

    tlb_op_unit #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .op_invtlb_op(op_invtlb_op), .op_asid(op_asid), .op_va(op_va), .op_done(op_done),
        .csr_asid(csr_asid), .csr_tlbehi(csr_tlbehi), .csr_tlbidx(csr_tlbidx),
        .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_estat_ecode(csr_estat_ecode),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid), .s1_found(s1_found),
        .s1_index(s1_index), .s1_owned(s1_owned), .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
        .srch_wb_valid(srch_wb_valid), .srch_wb_ne(srch_wb_ne), .srch_wb_index(srch_wb_index),
        .rd_wb_valid(rd_wb_valid), .rd_wb_ne(rd_wb_ne), .rd_wb_ps(rd_wb_ps), .rd_wb_asid(rd_wb_asid),
        .rd_wb_tlbehi(rd_wb_tlbehi), .rd_wb_tlbelo0(rd_wb_tlbelo0), .rd_wb_tlbelo1(rd_wb_tlbelo1)
    );

    int checks = 0, errors = 0;
    int fill_cnt = 0;

    logic          x_we, x_w_e, x_w_g, x_inv, x_owned, x_bit12, x_done;
    logic [IW-1:0] x_w_index, x_r_index;
    logic [18:0]   x_w_vppn, x_s1_vppn;
    logic [5:0]    x_w_ps;
    logic [9:0]    x_w_asid, x_s1_asid;
    logic [4:0]    x_inv_op;
    logic [25:0]   x_lo0, x_lo1;
    logic          y_done, y_we, y_inv, y_ready, y_sv, y_sne, y_rv, y_rne, z_ready;
    logic [IW-1:0] y_sidx;
    logic [5:0]    y_ps;
    logic [9:0]    y_asid;
    logic [31:0]   y_ehi, y_elo0, y_elo1;

    task automatic wait_ready();
        int n = 0;
        while (op_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: op_ready=%b required 1", op_ready);
        end
    endtask

    task automatic run_op(input logic [2:0] t, input logic [4:0] iop, input logic [9:0] ia, input logic [31:0] va);
        wait_ready();
        op_valid = 1'b1; op_type = t; op_invtlb_op = iop; op_asid = ia; op_va = va;
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 3'd7; op_invtlb_op = '0; op_asid = '0; op_va = '0;
        x_we = we; x_w_e = w_e; x_w_g = w_g; x_inv = invtlb_valid; x_owned = s1_owned;
        x_bit12 = s1_va_bit12; x_done = op_done; x_w_index = w_index; x_r_index = r_index;
        x_w_vppn = w_vppn; x_s1_vppn = s1_vppn; x_w_ps = w_ps; x_w_asid = w_asid; x_s1_asid = s1_asid;
        x_inv_op = invtlb_op;
        x_lo0 = {w_ppn0, w_mat0, w_plv0, w_d0, w_v0};
        x_lo1 = {w_ppn1, w_mat1, w_plv1, w_d1, w_v1};
        @(posedge clk); #1;
        y_done = op_done; y_we = we; y_inv = invtlb_valid; y_ready = op_ready;
        y_sv = srch_wb_valid; y_sne = srch_wb_ne; y_sidx = srch_wb_index;
        y_rv = rd_wb_valid; y_rne = rd_wb_ne; y_ps = rd_wb_ps; y_asid = rd_wb_asid;
        y_ehi = rd_wb_tlbehi; y_elo0 = rd_wb_tlbelo0; y_elo1 = rd_wb_tlbelo1;
        @(posedge clk); #1;
        z_ready = op_ready;
        if (t == 3'd3) fill_cnt = (fill_cnt + 1) % 16;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b need 0", op_ready); end
        checks++; if ({we, invtlb_valid, s1_owned, op_done, srch_wb_valid, rd_wb_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_outs: got %b need 000000", {we, invtlb_valid, s1_owned, op_done, srch_wb_valid, rd_wb_valid}); end
        reset = 1'b0;
        fill_cnt = 0;
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b need 1", op_ready); end
    endtask

    task automatic test_wr();
        csr_tlbidx = (32'd12 << 24) | 32'd5; csr_tlbehi = 32'h12346000; csr_asid = 10'h021;
        csr_tlbelo0 = 32'h0ABCDE5F; csr_tlbelo1 = 32'h01234541; csr_estat_ecode = 6'd0;
        run_op(3'd2, 5'd0, 10'd0, 32'd0);
        checks++; if (x_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b need 1", x_we); end
        checks++; if (x_w_index !== 4'd5) begin errors++; $display("FAIL wr_index: got %0d need 5", x_w_index); end
        checks++; if (x_w_vppn !== 19'h091A3) begin errors++; $display("FAIL wr_vppn: got %h need 091a3", x_w_vppn); end
        checks++; if (x_w_e !== 1'b1 || x_w_g !== 1'b1) begin errors++; $display("FAIL wr_e_g: got %b%b need 11", x_w_e, x_w_g); end
        checks++; if (x_w_ps !== 6'd12 || x_w_asid !== 10'h021) begin errors++; $display("FAIL wr_ps_asid: got %0d/%h need 12/021", x_w_ps, x_w_asid); end
        checks++; if (x_lo0 !== {20'hABCDE, 2'd1, 2'd3, 1'b1, 1'b1}) begin errors++; $display("FAIL wr_lo0: got %h", x_lo0); end
        checks++; if (x_lo1 !== {20'h12345, 2'd0, 2'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL wr_lo1: got %h", x_lo1); end
        checks++; if (x_done !== 1'b0 || y_done !== 1'b1 || y_we !== 1'b0) begin
            errors++; $display("FAIL wr_timing: exec_done=%b done=%b done_we=%b need 0 1 0", x_done, y_done, y_we); end
        checks++; if (y_ready !== 1'b0 || z_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b%b need 01", y_ready, z_ready); end
    endtask

    task automatic test_srch();
        csr_tlbehi = 32'h12346000; csr_asid = 10'h155; s1_found = 1'b1; s1_index = 4'd7;
        run_op(3'd0, 5'd0, 10'd0, 32'd0);
        checks++; if (x_owned !== 1'b1 || x_s1_vppn !== 19'h091A3 || x_bit12 !== 1'b0 || x_s1_asid !== 10'h155) begin
            errors++; $display("FAIL srch_key: owned=%b vppn=%h b12=%b asid=%h", x_owned, x_s1_vppn, x_bit12, x_s1_asid); end
        checks++; if (y_sv !== 1'b1 || y_sne !== 1'b0 || y_sidx !== 4'd7) begin
            errors++; $display("FAIL srch_hit: v=%b ne=%b idx=%0d need 1 0 7", y_sv, y_sne, y_sidx); end
        s1_found = 1'b0; s1_index = 4'd9;
        run_op(3'd0, 5'd0, 10'd0, 32'd0);
        checks++; if (y_sv !== 1'b1 || y_sne !== 1'b1 || y_sidx !== 4'd0) begin
            errors++; $display("FAIL srch_miss: v=%b ne=%b idx=%0d need 1 1 0", y_sv, y_sne, y_sidx); end
    endtask

    task automatic test_rd();
        csr_tlbidx = 32'd3;
        r_e = 1'b0; r_vppn = 19'h7FFFF; r_ps = 6'd21; r_asid = 10'h3FF; r_g = 1'b1;
        r_ppn0 = 20'hFFFFF; r_plv0 = 2'd3; r_mat0 = 2'd3; r_d0 = 1'b1; r_v0 = 1'b1;
        r_ppn1 = 20'hFFFFF; r_plv1 = 2'd3; r_mat1 = 2'd3; r_d1 = 1'b1; r_v1 = 1'b1;
        run_op(3'd1, 5'd0, 10'd0, 32'd0);
        checks++; if (x_r_index !== 4'd3) begin errors++; $display("FAIL rd_index: got %0d need 3", x_r_index); end
        checks++; if (y_rv !== 1'b1 || y_rne !== 1'b1 || y_ehi !== 0 || y_elo0 !== 0 || y_elo1 !== 0 || y_ps !== 0 || y_asid !== 0) begin
            errors++; $display("FAIL rd_empty: v=%b ne=%b ehi=%h elo0=%h elo1=%h ps=%0d asid=%h", y_rv, y_rne, y_ehi, y_elo0, y_elo1, y_ps, y_asid); end
        r_e = 1'b1; r_vppn = 19'h5A5A5; r_ps = 6'd21; r_asid = 10'h155; r_g = 1'b1;
        r_ppn0 = 20'hABCDE; r_plv0 = 2'd3; r_mat0 = 2'd1; r_d0 = 1'b1; r_v0 = 1'b1;
        r_ppn1 = 20'h12345; r_plv1 = 2'd0; r_mat1 = 2'd2; r_d1 = 1'b0; r_v1 = 1'b1;
        run_op(3'd1, 5'd0, 10'd0, 32'd0);
        checks++; if (y_rne !== 1'b0 || y_ehi !== 32'hB4B4A000 || y_ps !== 6'd21 || y_asid !== 10'h155) begin
            errors++; $display("FAIL rd_4m_hdr: ne=%b ehi=%h ps=%0d asid=%h need 0 b4b4a000 21 155", y_rne, y_ehi, y_ps, y_asid); end
        checks++; if (y_elo0 !== 32'h0ABCDE5F || y_elo1 !== 32'h01234561) begin
            errors++; $display("FAIL rd_4m_elo: elo0=%h elo1=%h need 0abcde5f 01234561", y_elo0, y_elo1); end
    endtask

    task automatic test_fill();
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0; fill_cnt = 0;
        csr_estat_ecode = 6'h3F; csr_tlbidx = 32'h8000000A;
        for (int i = 0; i < 17; i++) begin
            run_op(3'd3, 5'd0, 10'd0, 32'd0);
            checks++; if (x_we !== 1'b1 || x_w_index !== 4'(i % 16) || x_w_e !== 1'b1) begin
                errors++; $display("FAIL fill_%0d: we=%b idx=%0d e=%b need 1 %0d 1", i, x_we, x_w_index, x_w_e, i % 16); end
        end
        csr_estat_ecode = 6'd0;
        run_op(3'd3, 5'd0, 10'd0, 32'd0);
        checks++; if (x_w_index !== 4'd1 || x_w_e !== 1'b0) begin
            errors++; $display("FAIL fill_ne: idx=%0d e=%b need 1 0", x_w_index, x_w_e); end
    endtask

    task automatic test_inv();
        run_op(3'd4, 5'd5, 10'h021, 32'h12345000);
        checks++; if (x_inv !== 1'b1 || x_inv_op !== 5'd5 || y_inv !== 1'b0) begin
            errors++; $display("FAIL inv5_valid: exec=%b op=%0d done_cycle=%b need 1 5 0", x_inv, x_inv_op, y_inv); end
        checks++; if (x_owned !== 1'b1 || x_s1_vppn !== 19'h091A2 || x_bit12 !== 1'b1 || x_s1_asid !== 10'h021) begin
            errors++; $display("FAIL inv5_key: owned=%b vppn=%h b12=%b asid=%h need 1 091a2 1 021", x_owned, x_s1_vppn, x_bit12, x_s1_asid); end
        run_op(3'd4, 5'd9, 10'h021, 32'h12345000);
        checks++; if (x_inv !== 1'b0 || y_done !== 1'b1 || x_we !== 1'b0) begin
            errors++; $display("FAIL inv9: inv=%b done=%b we=%b need 0 1 0", x_inv, y_done, x_we); end
    endtask

    task automatic test_back_to_back();
        int cnt = 0, first = -1;
        wait_ready();
        op_valid = 1'b1; op_type = 3'd5;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (op_done === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        op_valid = 1'b0;
        checks++; if (cnt != 4 || first != 2) begin errors++; $display("FAIL b2b: pulses=%0d first=%0d need 4 2", cnt, first); end
    endtask

    task automatic test_random();
        logic [2:0] t;
        logic [4:0] iop;
        logic [9:0] ia;
        logic [31:0] va, e_ehi, e_elo0, e_elo1;
        logic e_we, e_e;
        int e_idx;
        for (int k = 0; k < 40; k++) begin
            t = 3'($urandom_range(0, 7)); iop = 5'($urandom); ia = 10'($urandom); va = $urandom;
            csr_asid = 10'($urandom); csr_tlbehi = $urandom; csr_tlbidx = $urandom;
            csr_tlbelo0 = $urandom; csr_tlbelo1 = $urandom;
            csr_estat_ecode = ($urandom % 2) ? 6'h3F : 6'($urandom);
            s1_found = 1'($urandom); s1_index = 4'($urandom);
            r_e = 1'($urandom); r_vppn = 19'($urandom); r_ps = 6'($urandom); r_asid = 10'($urandom);
            r_g = 1'($urandom); r_ppn0 = 20'($urandom); r_plv0 = 2'($urandom); r_mat0 = 2'($urandom);
            r_d0 = 1'($urandom); r_v0 = 1'($urandom); r_ppn1 = 20'($urandom); r_plv1 = 2'($urandom);
            r_mat1 = 2'($urandom); r_d1 = 1'($urandom); r_v1 = 1'($urandom);
            e_we = (t == 3'd2) || (t == 3'd3);
            e_idx = (t == 3'd2) ? int'(csr_tlbidx % 16) : (t == 3'd3) ? fill_cnt : 0;
            e_e = e_we && (csr_estat_ecode == 6'h3F || csr_tlbidx < 32'h80000000);
            e_ehi = (t == 3'd1 && r_e) ? 32'(r_vppn) * 32'd8192 : 32'd0;
            e_elo0 = (t == 3'd1 && r_e) ? (32'(r_ppn0) << 8) + (32'(r_g) << 6) + (32'(r_mat0) << 4) + (32'(r_plv0) << 2) + (32'(r_d0) << 1) + 32'(r_v0) : 32'd0;
            e_elo1 = (t == 3'd1 && r_e) ? (32'(r_ppn1) << 8) + (32'(r_g) << 6) + (32'(r_mat1) << 4) + (32'(r_plv1) << 2) + (32'(r_d1) << 1) + 32'(r_v1) : 32'd0;
            run_op(t, iop, ia, va);
            checks++; if (x_we !== e_we || int'(x_w_index) != e_idx || x_w_e !== e_e) begin
                errors++; $display("FAIL rnd%0d_write: t=%0d we=%b idx=%0d e=%b need %b %0d %b", k, t, x_we, x_w_index, x_w_e, e_we, e_idx, e_e); end
            checks++; if (e_we && (x_w_vppn !== 19'(csr_tlbehi / 8192) || x_w_g !== (csr_tlbelo0[6] & csr_tlbelo1[6]) || x_w_ps !== 6'((csr_tlbidx / 32'h01000000) % 64))) begin
                errors++; $display("FAIL rnd%0d_wfields: vppn=%h g=%b ps=%0d", k, x_w_vppn, x_w_g, x_w_ps); end
            checks++; if (x_inv !== (t == 3'd4 && iop <= 5'd6) || x_owned !== (t == 3'd0 || t == 3'd4)) begin
                errors++; $display("FAIL rnd%0d_inv: t=%0d op=%0d inv=%b owned=%b", k, t, iop, x_inv, x_owned); end
            checks++; if (y_done !== 1'b1 || z_ready !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_done: done=%b ready=%b need 1 1", k, y_done, z_ready); end
            checks++; if (y_sv !== (t == 3'd0) || y_sne !== (t == 3'd0 && !s1_found) || y_sidx !== ((t == 3'd0 && s1_found) ? s1_index : 4'd0)) begin
                errors++; $display("FAIL rnd%0d_srch: v=%b ne=%b idx=%0d", k, y_sv, y_sne, y_sidx); end
            checks++; if (y_rv !== (t == 3'd1) || y_rne !== (t == 3'd1 && !r_e) || y_ehi !== e_ehi || y_elo0 !== e_elo0 || y_elo1 !== e_elo1) begin
                errors++; $display("FAIL rnd%0d_rd: v=%b ne=%b ehi=%h/%h elo0=%h/%h elo1=%h/%h", k, y_rv, y_rne, y_ehi, e_ehi, y_elo0, e_elo0, y_elo1, e_elo1); end
        end
    endtask

    task automatic test_reset_exec();
        int dn = 0;
        csr_estat_ecode = 6'd0; csr_tlbidx = 32'd2;
        run_op(3'd3, 5'd0, 10'd0, 32'd0);
        wait_ready();
        op_valid = 1'b1; op_type = 3'd2;
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 3'd7;
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL rstx_pre_we: got %b need 1", we); end
        reset = 1'b1; #1;
        checks++; if (we !== 1'b0 || op_ready !== 1'b0 || s1_owned !== 1'b0) begin
            errors++; $display("FAIL rstx_gate: we=%b ready=%b owned=%b need 0 0 0", we, op_ready, s1_owned); end
        @(posedge clk); #1;
        reset = 1'b0; fill_cnt = 0; #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rstx_ready: got %b need 1", op_ready); end
        for (int i = 0; i < 3; i++) begin
            if (op_done === 1'b1) dn++;
            @(posedge clk); #1;
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL rstx_no_done: pulses=%0d need 0", dn); end
        run_op(3'd3, 5'd0, 10'd0, 32'd0);
        checks++; if (x_w_index !== 4'd0) begin errors++; $display("FAIL rstx_fill_idx: got %0d need 0", x_w_index); end
    endtask

    initial begin
        test_reset();
        test_wr();
        test_srch();
        test_rd();
        test_fill();
        test_inv();
        test_back_to_back();
        test_random();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
